div_share_arb: RTL

//  Round-robin arbiter/sequencer sharing one serial divider (div) among NREQ requesters.

---
 rtl/div_share_if.sv | 33 +++
 rtl/div_share_arb.sv | 132 +++++++++++++
 2 files changed

// File: rtl/div_share_if.sv
// div_share_if: requester and shared-divider signal bundle for div_share_arb.
interface div_share_if #(
    parameter int NREQ    = 4,
    parameter int BW_DEND = 8,
    parameter int BW_DSOR = 4,
    parameter int BW_TO   = 8
);
    logic [NREQ-1:0]         req;
    logic [NREQ-1:0]         gnt;
    logic [NREQ-1:0]         done;
    logic [NREQ*BW_DEND-1:0] dend_in;
    logic [NREQ*BW_DSOR-1:0] dsor_in;
    logic [BW_TO-1:0]        timeout;
    logic [BW_DEND-1:0]      quot;
    logic [BW_DSOR-1:0]      rem;
    logic                    err;
    logic                    div_start;
    logic [BW_DEND-1:0]      div_dividend;
    logic [BW_DSOR-1:0]      div_divisor;
    logic                    div_busy;
    logic [BW_DEND-1:0]      div_quot;
    logic [BW_DSOR-1:0]      div_rem;

    modport slave (
        input  req, dend_in, dsor_in, timeout, div_busy, div_quot, div_rem,
        output gnt, done, quot, rem, err, div_start, div_dividend, div_divisor
    );

    modport master (
        output req, dend_in, dsor_in, timeout, div_busy, div_quot, div_rem,
        input  gnt, done, quot, rem, err, div_start, div_dividend, div_divisor
    );
endinterface

// File: rtl/div_share_arb.sv
// div_share_arb: round-robin arbiter sharing one serial divider among NREQ requesters.
// Optional macro DIV_SHARE_TIMEOUT_EN adds a WAIT/RUN watchdog that aborts with ERR and all-ones results.
module div_share_arb #(
    parameter int NREQ    = 4,
    parameter int BW_DEND = 8,
    parameter int BW_DSOR = 4,
    parameter int BW_TO   = 8
) (
    input logic        clk,
    input logic        rstx,
    div_share_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RUN} state_t;

    state_t             state;
    logic [PW-1:0]      ptr;
    logic [PW-1:0]      win;
    logic [PW-1:0]      c;
    logic               found;
    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [BW_DEND-1:0] quot;
    logic [BW_DEND-1:0] dividend;
    logic [BW_DSOR-1:0] rem;
    logic [BW_DSOR-1:0] divisor;
    logic               div_start;
    logic               err;

`ifdef DIV_SHARE_TIMEOUT_EN
    logic [BW_TO-1:0] cnt;
    logic [BW_TO:0]   limit;

    // A zero timeout still allows one cycle in WAIT/RUN
    assign limit = (bus.timeout == '0) ? (BW_TO+1)'(1) : {1'b0, bus.timeout};
`else
    logic [BW_TO-1:0] unused_timeout;

    assign unused_timeout = bus.timeout;
    assign err = 1'b0;
`endif

    // A requester seeing its own DONE is masked so it cannot win back-to-back
    assign elig = bus.req & ~done;

    // First eligible requester searching upward from the one after the last winner
    always_comb begin
        win = ptr;
        found = 1'b0;
        c = ptr;
        for (int k = 1; k <= NREQ; k++) begin
            c = PW'((int'(ptr) + k) % NREQ);
            if (!found && elig[c]) begin
                found = 1'b1;
                win = c;
            end
        end
    end

    // Grant, start the divider, wait for BUSY to rise and fall, then return the result
    always_ff @(posedge clk or negedge rstx) begin
        if (!rstx) begin
            state <= IDLE;
            ptr <= PW'(NREQ - 1);
            gnt <= '0;
            done <= '0;
            quot <= '0;
            rem <= '0;
            div_start <= 1'b0;
            dividend <= '0;
            divisor <= '0;
`ifdef DIV_SHARE_TIMEOUT_EN
            err <= 1'b0;
            cnt <= '0;
`endif
        end else begin
            div_start <= 1'b0;
            done <= '0;
`ifdef DIV_SHARE_TIMEOUT_EN
            err <= 1'b0;
`endif
            case (state)
                IDLE: if (found) begin
                    gnt <= NREQ'(1) << win;
                    div_start <= 1'b1;
                    dividend <= bus.dend_in[int'(win)*BW_DEND +: BW_DEND];
                    divisor <= bus.dsor_in[int'(win)*BW_DSOR +: BW_DSOR];
                    ptr <= win;
                    state <= WAIT;
`ifdef DIV_SHARE_TIMEOUT_EN
                    cnt <= '0;
`endif
                end
                WAIT: if (bus.div_busy) state <= RUN;
                RUN: if (!bus.div_busy) begin
                    quot <= bus.div_quot;
                    rem <= bus.div_rem;
                    done <= gnt;
                    gnt <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef DIV_SHARE_TIMEOUT_EN
            // Watchdog overrides a normal completion landing on the same edge
            if (state != IDLE) begin
                if (({1'b0, cnt} + (BW_TO+1)'(1)) >= limit) begin
                    quot <= '1;
                    rem <= '1;
                    done <= gnt;
                    err <= 1'b1;
                    gnt <= '0;
                    state <= IDLE;
                end else begin
                    cnt <= cnt + BW_TO'(1);
                end
            end
`endif
        end
    end

    assign bus.gnt = gnt;
    assign bus.done = done;
    assign bus.quot = quot;
    assign bus.rem = rem;
    assign bus.err = err;
    assign bus.div_start = div_start;
    assign bus.div_dividend = dividend;
    assign bus.div_divisor = divisor;
endmodule
